// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, SPI_MODE bit positions
// and the number of SCLK edges that make up one byte.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT_NEXT,
      ST_CS_HOLD,
      ST_CS_GAP
   } spi_state_e;

   localparam int CPOL_BIT       = 1;
   localparam int CPHA_BIT       = 0;
   localparam int EDGES_PER_BYTE = 16;

   function automatic logic mode_bit(input int mode, input int pos);
      return 1'((mode >> pos) & 1);
   endfunction

endpackage

// File: rtl/spi_master_cs_if.sv
// Byte-stream and SPI pin bundle for spi_master_cs; the master modport is the
// controller's view, the slave modport is the view of whatever drives/observes it.
interface spi_master_cs_if;

   logic [4:0] tx_count;
   logic [7:0] tx_byte;
   logic       tx_dv;
   logic       tx_ready;
   logic [4:0] rx_count;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       sclk;
   logic       miso;
   logic       mosi;
   logic       cs_n;

   modport master (
      input  tx_count, tx_byte, tx_dv, miso,
      output tx_ready, rx_count, rx_byte, rx_dv, sclk, mosi, cs_n
   );

   modport slave (
      output tx_count, tx_byte, tx_dv, miso,
      input  tx_ready, rx_count, rx_byte, rx_dv, sclk, mosi, cs_n
   );

endinterface

// File: rtl/spi_edge_gen.sv
// SCLK generator: toggles every CLKS_PER_HALF_BIT cycles while enabled and
// flags the cycle before each leading/trailing edge with a one-cycle strobe.
module spi_edge_gen
   import spi_pkg::*;
#(
   parameter int   CLKS_PER_HALF_BIT = 2,
   parameter logic CPOL              = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   output logic sclk_o,
   output logic lead_o,
   output logic trail_o
);

   localparam int CW = $clog2(CLKS_PER_HALF_BIT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          half_done;

   assign half_done = en_i && (cnt_q == CW'(CLKS_PER_HALF_BIT - 1));

   // Disabling snaps SCLK back to its idle level and restarts the half-period.
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = CPOL;
      end else if (half_done) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q  <= '0;
         sclk_q <= CPOL;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o  = sclk_q;
   assign lead_o  = half_done && (sclk_q == CPOL);
   assign trail_o = half_done && (sclk_q != CPOL);

endmodule

// File: rtl/spi_master_cs.sv
// SPI master that keeps CS_n asserted across a multi-byte frame, with a
// guaranteed CS_n-high gap between frames.
module spi_master_cs
   import spi_pkg::*;
#(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int CS_INACTIVE_CLKS  = 4
) (
   input  logic       i_FPGA_clk,
   input  logic       i_FPGA_rst,
   input  logic [4:0] i_TX_Count,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic [4:0] o_RX_Count,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_DV,
   output logic       o_SPI_Clk,
   input  logic       i_SPI_MISO,
   output logic       o_SPI_MOSI,
   output logic       o_SPI_CS_n
);

   localparam logic CPOL = mode_bit(SPI_MODE, CPOL_BIT);
   localparam logic CPHA = mode_bit(SPI_MODE, CPHA_BIT);
   localparam int   TW   = 16;

   spi_state_e    state_q, state_d;
   logic [4:0]    remain_q, remain_d;
   logic [4:0]    idx_q, idx_d;
   logic [3:0]    edge_cnt_q, edge_cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [7:0]    tx_sr_q, tx_sr_d;
   logic [7:0]    rx_sr_q, rx_sr_d;
   logic          mosi_q, mosi_d;
   logic          cs_n_q, cs_n_d;
   logic          rx_dv_q, rx_dv_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic [4:0]    rx_cnt_q, rx_cnt_d;

   logic       sclk, lead, trail;
   logic       shift_stb, sample_stb, accept, byte_done, ready;
   logic [7:0] rx_next;
   logic [4:0] first_cnt;

   spi_edge_gen #(
      .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
      .CPOL             (CPOL)
   ) u_edge_gen (
      .clk_i  (i_FPGA_clk),
      .rst_n_i(i_FPGA_rst),
      .en_i   (state_q == ST_SHIFT),
      .sclk_o (sclk),
      .lead_o (lead),
      .trail_o(trail)
   );

   assign ready      = (state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT);
   assign accept     = ready && i_TX_DV;
   assign shift_stb  = CPHA ? lead : trail;
   assign sample_stb = CPHA ? trail : lead;
   assign rx_next    = sample_stb ? {rx_sr_q[6:0], i_SPI_MISO} : rx_sr_q;
   assign byte_done  = (lead || trail) && (edge_cnt_q == 4'(EDGES_PER_BYTE - 1));
   assign first_cnt  = (i_TX_Count == '0) ? 5'd1 : i_TX_Count;

   always_comb begin
      state_d    = state_q;
      remain_d   = remain_q;
      idx_d      = idx_q;
      edge_cnt_d = edge_cnt_q;
      tmr_d      = '0;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      mosi_d     = mosi_q;
      rx_dv_d    = 1'b0;
      rx_byte_d  = rx_byte_q;
      rx_cnt_d   = rx_cnt_q;

      // With CPHA=0 the first bit must already be on MOSI before the first edge.
      if (accept) begin
         state_d    = ST_SHIFT;
         edge_cnt_d = '0;
         rx_sr_d    = '0;
         if (state_q == ST_IDLE) begin
            remain_d = first_cnt - 5'd1;
            idx_d    = '0;
         end else begin
            remain_d = remain_q - 5'd1;
         end
         if (CPHA) begin
            tx_sr_d = i_TX_Byte;
         end else begin
            mosi_d  = i_TX_Byte[7];
            tx_sr_d = {i_TX_Byte[6:0], 1'b0};
         end
      end

      unique case (state_q)
         ST_SHIFT: begin
            if (lead || trail) edge_cnt_d = edge_cnt_q + 4'd1;
            if (shift_stb) begin
               mosi_d  = tx_sr_q[7];
               tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
            rx_sr_d = rx_next;
            if (byte_done) begin
               rx_dv_d   = 1'b1;
               rx_byte_d = rx_next;
               rx_cnt_d  = idx_q;
               idx_d     = idx_q + 5'd1;
               state_d   = (remain_q == '0) ? ST_CS_HOLD : ST_WAIT_NEXT;
            end
         end
         ST_CS_HOLD: begin
            if (tmr_q == TW'(CLKS_PER_HALF_BIT - 1)) state_d = ST_CS_GAP;
            else                                     tmr_d   = tmr_q + 1'b1;
         end
         ST_CS_GAP: begin
            if (tmr_q == TW'(CS_INACTIVE_CLKS - 1)) state_d = ST_IDLE;
            else                                    tmr_d   = tmr_q + 1'b1;
         end
         default: ;
      endcase

      cs_n_d = !(state_d inside {ST_SHIFT, ST_WAIT_NEXT, ST_CS_HOLD});
   end

   always_ff @(posedge i_FPGA_clk or negedge i_FPGA_rst) begin
      if (!i_FPGA_rst) begin
         state_q    <= ST_IDLE;
         remain_q   <= '0;
         idx_q      <= '0;
         edge_cnt_q <= '0;
         tmr_q      <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         rx_dv_q    <= 1'b0;
         rx_byte_q  <= '0;
         rx_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         remain_q   <= remain_d;
         idx_q      <= idx_d;
         edge_cnt_q <= edge_cnt_d;
         tmr_q      <= tmr_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         rx_dv_q    <= rx_dv_d;
         rx_byte_q  <= rx_byte_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   assign o_TX_Ready = ready;
   assign o_RX_Count = rx_cnt_q;
   assign o_RX_Byte  = rx_byte_q;
   assign o_RX_DV    = rx_dv_q;
   assign o_SPI_Clk  = sclk;
   assign o_SPI_MOSI = mosi_q;
   assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Mode-0 and mode-3 masters driven by one random byte stream; a pin-level SPI
// slave model supplies MISO and records MOSI/MISO at every rising SCLK edge.
module tb_spi_master_cs;

   localparam int CPHB     = 2;
   localparam int CSI      = 4;
   localparam int NDUT     = 2;
   localparam int BYTE_CYC = 16 * CPHB;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [4:0] tx_count = '0;
   logic [7:0] tx_byte  = '0;
   logic       tx_dv    = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]  fixed_bytes [4];
   logic [31:0] edge_base [NDUT];

   wire        tx_ready_w [NDUT];
   wire        rx_dv_w    [NDUT];
   wire [7:0]  rx_byte_w  [NDUT];
   wire [4:0]  rx_count_w [NDUT];
   wire        sclk_w     [NDUT];
   wire        mosi_w     [NDUT];
   wire        cs_n_w     [NDUT];
   wire [7:0]  mosi_cap_w [NDUT];
   wire [7:0]  miso_cap_w [NDUT];
   wire [31:0] edges_w    [NDUT];

   always #5 clk = ~clk;

   function automatic int mode_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic logic cpol_of(input int d);
      return 1'((mode_of(d) >> 1) & 1);
   endfunction

   for (genvar g = 0; g < NDUT; g++) begin : gen_dut
      spi_master_cs_if bus ();
      logic [7:0] mosi_cap = '0;
      logic [7:0] miso_cap = '0;
      int         edges    = 0;

      assign bus.tx_count = tx_count;
      assign bus.tx_byte  = tx_byte;
      assign bus.tx_dv    = tx_dv;

      spi_master_cs #(
         .SPI_MODE         ((g == 0) ? 0 : 3),
         .CLKS_PER_HALF_BIT(CPHB),
         .CS_INACTIVE_CLKS (CSI)
      ) dut (
         .i_FPGA_clk(clk),
         .i_FPGA_rst(rst_n),
         .i_TX_Count(bus.tx_count),
         .i_TX_Byte (bus.tx_byte),
         .i_TX_DV   (bus.tx_dv),
         .o_TX_Ready(bus.tx_ready),
         .o_RX_Count(bus.rx_count),
         .o_RX_Byte (bus.rx_byte),
         .o_RX_DV   (bus.rx_dv),
         .o_SPI_Clk (bus.sclk),
         .i_SPI_MISO(bus.miso),
         .o_SPI_MOSI(bus.mosi),
         .o_SPI_CS_n(bus.cs_n)
      );

      // MISO moves shortly after every SCLK/CS_n transition, never on one.
      always @(bus.sclk or bus.cs_n) begin
         #1;
         bus.miso = 1'($urandom_range(0, 1));
      end

      // Modes 0 and 3 both sample on the rising SCLK edge.
      always @(posedge bus.sclk) begin
         mosi_cap <= {mosi_cap[6:0], bus.mosi};
         miso_cap <= {miso_cap[6:0], bus.miso};
      end

      always @(bus.sclk) begin
         if (bus.cs_n === 1'b0) edges <= edges + 1;
      end

      assign tx_ready_w[g] = bus.tx_ready;
      assign rx_dv_w[g]    = bus.rx_dv;
      assign rx_byte_w[g]  = bus.rx_byte;
      assign rx_count_w[g] = bus.rx_count;
      assign sclk_w[g]     = bus.sclk;
      assign mosi_w[g]     = bus.mosi;
      assign cs_n_w[g]     = bus.cs_n;
      assign mosi_cap_w[g] = mosi_cap;
      assign miso_cap_w[g] = miso_cap;
      assign edges_w[g]    = 32'(edges);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_ctl(input string tag, input bit cs_n_e, input bit ready_e, input bit rx_dv_e);
      for (int d = 0; d < NDUT; d++) begin
         check_val($sformatf("m%0d %s cs_n", mode_of(d), tag), 32'(cs_n_w[d]), 32'(cs_n_e));
         check_val($sformatf("m%0d %s ready", mode_of(d), tag), 32'(tx_ready_w[d]), 32'(ready_e));
         check_val($sformatf("m%0d %s rx_dv", mode_of(d), tag), 32'(rx_dv_w[d]), 32'(rx_dv_e));
      end
   endtask

   task automatic check_sclk_idle(input string tag);
      for (int d = 0; d < NDUT; d++)
         check_val($sformatf("m%0d %s sclk", mode_of(d), tag), 32'(sclk_w[d]), 32'(cpol_of(d)));
   endtask

   task automatic check_reset_state(input string tag);
      check_ctl(tag, 1'b1, 1'b1, 1'b0);
      check_sclk_idle(tag);
      for (int d = 0; d < NDUT; d++) begin
         check_val($sformatf("m%0d %s mosi", mode_of(d), tag), 32'(mosi_w[d]), 32'd0);
         check_val($sformatf("m%0d %s rx_byte", mode_of(d), tag), 32'(rx_byte_w[d]), 32'd0);
         check_val($sformatf("m%0d %s rx_count", mode_of(d), tag), 32'(rx_count_w[d]), 32'd0);
      end
   endtask

   // Called at a falling clk edge where the model expects ready=1.
   task automatic launch(input bit first, input logic [4:0] cnt, input logic [7:0] b);
      check_ctl("pre-accept", first, 1'b1, !first && rx_dv_w[0]);
      tx_dv    = 1'b1;
      tx_byte  = b;
      tx_count = first ? cnt : 5'($urandom);
      @(posedge clk);
      @(negedge clk);
      tx_dv    = 1'b0;
      tx_byte  = 8'($urandom);
      tx_count = 5'($urandom);
      for (int d = 0; d < NDUT; d++) edge_base[d] = edges_w[d];
      check_ctl("post-accept", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic finish_byte(input int idx, input logic [7:0] b, input bit last);
      for (int c = 1; c < BYTE_CYC; c++) begin
         @(negedge clk);
         // A request while busy must be ignored.
         tx_dv = (c == 10);
         if (c == 10) tx_byte = 8'($urandom);
         for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("m%0d busy ready", mode_of(d)), 32'(tx_ready_w[d]), 32'd0);
            check_val($sformatf("m%0d busy rx_dv", mode_of(d)), 32'(rx_dv_w[d]), 32'd0);
         end
      end
      @(negedge clk);
      tx_dv = 1'b0;
      check_ctl("byte-done", 1'b0, !last, 1'b1);
      check_sclk_idle("byte-done");
      for (int d = 0; d < NDUT; d++) begin
         check_val($sformatf("m%0d rx_byte", mode_of(d)), 32'(rx_byte_w[d]), 32'(miso_cap_w[d]));
         check_val($sformatf("m%0d rx_count", mode_of(d)), 32'(rx_count_w[d]), 32'(idx));
         check_val($sformatf("m%0d mosi bits", mode_of(d)), 32'(mosi_cap_w[d]), 32'(b));
         check_val($sformatf("m%0d edge count", mode_of(d)), edges_w[d] - edge_base[d], 32'd16);
      end
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_ctl("wait-next", 1'b0, 1'b1, 1'b0);
         check_sclk_idle("wait-next");
         for (int d = 0; d < NDUT; d++)
            check_val($sformatf("m%0d wait edges", mode_of(d)), edges_w[d] - edge_base[d], 32'd16);
      end
   endtask

   task automatic frame_tail();
      for (int k = 1; k <= CPHB + CSI; k++) begin
         @(negedge clk);
         check_ctl($sformatf("tail%0d", k), k >= CPHB, k >= CPHB + CSI, 1'b0);
         check_sclk_idle("tail");
      end
   endtask

   task automatic run_frame(input int cnt, input int hold_idx, input int hold_len, input bit fixed);
      int         n;
      logic [7:0] b;
      n = (cnt == 0) ? 1 : cnt;
      for (int i = 0; i < n; i++) begin
         b = fixed ? fixed_bytes[i] : 8'($urandom);
         launch(i == 0, 5'(cnt), b);
         finish_byte(i, b, i == n - 1);
         if (i < n - 1) idle_gap((i == hold_idx) ? hold_len : int'($urandom_range(0, 2)));
      end
      frame_tail();
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);

      fixed_bytes = '{8'h31, 8'h23, 8'h00, 8'h00};
      run_frame(3, -1, 0, 1'b1);

      run_frame(3, 1, 20, 1'b0);

      fixed_bytes[0] = 8'hA5;
      run_frame(0, -1, 0, 1'b1);

      fixed_bytes[0] = 8'h81;
      run_frame(1, -1, 0, 1'b1);

      repeat (6) run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                           int'($urandom_range(0, 25)), 1'b0);

      run_frame(31, 7, 3, 1'b0);

      // Abort a byte after five edges, then expect a clean fresh frame.
      launch(1'b1, 5'd2, 8'($urandom));
      repeat (5 * CPHB) @(negedge clk);
      for (int d = 0; d < NDUT; d++)
         check_val($sformatf("m%0d edges before reset", mode_of(d)), edges_w[d] - edge_base[d], 32'd5);
      #1 rst_n = 1'b0;
      #1 check_reset_state("mid-byte reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_frame(2, 0, 1, 1'b0);
      run_frame(int'($urandom_range(1, 4)), -1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want run completion");
      $fatal(1, "watchdog expired");
   end

endmodule
